pc_gen: RTL and testbench



---
 rtl/core_pkg.sv | 15 +
 rtl/ras_stack.sv | 66 ++++++
 rtl/pc_gen.sv | 124 ++++++++++++
 tb/tb_pc_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core's program-counter path.
// Defaults for PC width, reset vector and sequential increment live here.
package core_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int          XLEN_DEFAULT      = 32;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam int          INC_DEFAULT       = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; overwrites the oldest entry when full.
// Flush clears the occupancy count only; stale entries are masked by count.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  entry_reg [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_reg, ptr_next, top_idx, wr_idx;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             wr_en;

  assign top_idx = ptr_reg - PTR_W'(1);
  assign empty   = (count_reg == '0);
  assign top     = empty ? '0 : entry_reg[top_idx];

  always_comb begin
    ptr_next   = ptr_reg;
    count_next = count_reg;
    wr_en      = 1'b0;
    wr_idx     = ptr_reg;
    if (flush) begin
      count_next = '0;
    end else if (push && pop && !empty) begin
      // Simultaneous call/return: replace the top in place
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      wr_en    = 1'b1;
      ptr_next = ptr_reg + PTR_W'(1);
      if (count_reg != CNT_W'(RAS_DEPTH))
        count_next = count_reg + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_next   = top_idx;
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      entry_reg[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter unit: PC register, next-PC select, BOOT/RUN/HALT FSM and RAS.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirects and pulse misalign.
module pc_gen
  import core_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT),
  parameter int              RAS_DEPTH = 4,
  parameter int              INC       = INC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            halted,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            misalign
);

  pc_state_t       state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            misalign_reg, misalign_next;
  logic            ras_flush, ras_push_en, ras_pop_en;
  logic [XLEN-1:0] trap_dest, redir_dest;
  logic            trap_mis, redir_mis;

  assign trap_dest = trap_vec & ~XLEN'(3);

`ifdef PC_ALIGN_CHECK_EN
  assign trap_mis   = |trap_vec[1:0];
  assign redir_mis  = |redirect_target[1:0];
  assign redir_dest = redir_mis ? trap_dest : redirect_target;
`else
  assign trap_mis   = 1'b0;
  assign redir_mis  = 1'b0;
  assign redir_dest = redirect_target & ~XLEN'(3);
`endif

  assign pc       = pc_reg;
  assign pc_plus4 = pc_reg + XLEN'(INC);
  assign pc_valid = (state_reg == RUN);
  assign halted   = (state_reg == HALT);
  assign misalign = misalign_reg;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    misalign_next = 1'b0;
    ras_flush     = 1'b0;
    ras_push_en   = 1'b0;
    ras_pop_en    = 1'b0;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        ras_push_en = ras_push;
        ras_pop_en  = ras_pop;
        if (trap) begin
          pc_next       = trap_dest;
          ras_flush     = 1'b1;
          misalign_next = trap_mis;
        end else if (redirect_valid) begin
          pc_next       = redir_dest;
          ras_flush     = redir_mis;
          misalign_next = redir_mis;
        end else if (halt_req) begin
          state_next = HALT;
        end else if (!stall) begin
          pc_next = pc_plus4;
        end
      end
      HALT: begin
        ras_push_en = ras_push;
        ras_pop_en  = ras_pop;
        if (trap) begin
          state_next    = RUN;
          pc_next       = trap_dest;
          ras_flush     = 1'b1;
          misalign_next = trap_mis;
        end else if (resume) begin
          state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= BOOT;
      pc_reg       <= RESET_VEC;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      misalign_reg <= misalign_next;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .flush     (ras_flush),
    .push      (ras_push_en),
    .pop       (ras_pop_en),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: vector table plus reset/wrap sequences.
// Expectations for the misalign rows follow PC_ALIGN_CHECK_EN.
module tb_pc_gen;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, halt_req, resume, redirect_valid, trap, ras_push, ras_pop;
  logic [31:0] redirect_target, trap_vec;
  logic [31:0] pc, pc_plus4, ras_top;
  logic        pc_valid, halted, ras_empty, misalign;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .halt_req        (halt_req),
    .resume          (resume),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .trap_vec        (trap_vec),
    .ras_push        (ras_push),
    .ras_pop         (ras_pop),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .pc_valid        (pc_valid),
    .halted          (halted),
    .ras_top         (ras_top),
    .ras_empty       (ras_empty),
    .misalign        (misalign)
  );

  typedef struct {
    logic        stall, rv;
    logic [31:0] rt;
    logic        trap;
    logic [31:0] tv;
    logic        hreq, res, push, pop;
    logic [31:0] e_pc;
    logic        e_valid, e_halted;
    logic [31:0] e_top;
    logic        e_empty, e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic rv, logic [31:0] rt, logic tr, logic [31:0] tv,
                              logic hq, logic rs, logic pu, logic po, logic [31:0] epc,
                              logic ev, logic eh, logic [31:0] etop, logic ee, logic em);
    vec_t v;
    v.stall = st; v.rv = rv; v.rt = rt; v.trap = tr; v.tv = tv;
    v.hreq = hq; v.res = rs; v.push = pu; v.pop = po;
    v.e_pc = epc; v.e_valid = ev; v.e_halted = eh; v.e_top = etop; v.e_empty = ee; v.e_mis = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; halt_req = 0; resume = 0; redirect_valid = 0; trap = 0;
    ras_push = 0; ras_pop = 0; redirect_target = '0; trap_vec = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    // Vectors start in RUN with pc=0 after the boot bubble
    //               st rv rt            tr tv           hq rs pu po  pc            v  h  top    e  mis
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 32'h4,        1, 0, 32'h0,  1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 32'h8,        1, 0, 32'h0,  1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 32'hC,        1, 0, 32'h0,  1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 32'h10,       1, 0, 32'h0,  1, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 32'h10,       1, 0, 32'h0,  1, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 32'h10,       1, 0, 32'h0,  1, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 32'h10,       1, 0, 32'h0,  1, 0));
    vecs.push_back(mk(1, 1, 32'h100,      0, 32'h0,       0, 0, 0, 0, 32'h100,      1, 0, 32'h0,  1, 0));
    vecs.push_back(mk(0, 1, 32'h200,      1, 32'h80,      0, 0, 1, 0, 32'h80,       1, 0, 32'h0,  1, 0));
    vecs.push_back(mk(0, 1, 32'h0,        0, 32'h0,       0, 0, 0, 0, 32'h0,        1, 0, 32'h0,  1, 0));
    // Five pushes overflow a 4-deep stack
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 1, 0, 32'h4,        1, 0, 32'h4,  0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 1, 0, 32'h8,        1, 0, 32'h8,  0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 1, 0, 32'hC,        1, 0, 32'hC,  0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 1, 0, 32'h10,       1, 0, 32'h10, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 1, 0, 32'h14,       1, 0, 32'h14, 0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,       0, 0, 0, 1, 32'h14,       1, 0, 32'h10, 0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,       0, 0, 0, 1, 32'h14,       1, 0, 32'hC,  0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,       0, 0, 0, 1, 32'h14,       1, 0, 32'h8,  0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,       0, 0, 0, 1, 32'h14,       1, 0, 32'h0,  1, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,       0, 0, 0, 1, 32'h14,       1, 0, 32'h0,  1, 0));
    // Push+pop: acts as push when empty, replaces top otherwise
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,       0, 0, 1, 1, 32'h14,       1, 0, 32'h18, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 32'h18,       1, 0, 32'h18, 0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,       0, 0, 1, 1, 32'h18,       1, 0, 32'h1C, 0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,       0, 0, 0, 1, 32'h18,       1, 0, 32'h0,  1, 0));
    // HALT entry, RAS push while halted, resume
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       1, 0, 0, 0, 32'h18,       0, 1, 32'h0,  1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 32'h18,       0, 1, 32'h0,  1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 1, 0, 32'h18,       0, 1, 32'h1C, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 1, 0, 0, 32'h18,       1, 0, 32'h1C, 0, 0));
    vecs.push_back(mk(0, 1, 32'h300,      0, 32'h0,       1, 0, 0, 0, 32'h300,      1, 0, 32'h1C, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       1, 0, 0, 0, 32'h300,      0, 1, 32'h1C, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h40,      0, 1, 0, 0, 32'h40,       1, 0, 32'h0,  1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 32'h44,       1, 0, 32'h0,  1, 0));
    // Misaligned redirect and misaligned trap vector
    vecs.push_back(mk(0, 1, 32'h102,      0, 32'h80,      0, 0, 0, 0, ALIGN ? 32'h80 : 32'h100, 1, 0, 32'h0, 1, ALIGN));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, ALIGN ? 32'h84 : 32'h104, 1, 0, 32'h0, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h43,      0, 0, 0, 0, 32'h40,       1, 0, 32'h0,  1, ALIGN));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 32'h44,       1, 0, 32'h0,  1, 0));

    // Reset state, then one BOOT bubble
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(pc_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_empty", 32'(ras_empty), 32'h1);
    chk("rst_top", ras_top, 32'h0);
    chk("rst_mis", 32'(misalign), 32'h0);
    chk("rst_plus4", pc_plus4, 32'h4);
    rst = 1'b0;
    #1;
    chk("boot_pc", pc, 32'h0);
    chk("boot_valid", 32'(pc_valid), 32'h0);
    step();
    chk("run_pc", pc, 32'h0);
    chk("run_valid", 32'(pc_valid), 32'h1);
    $display("[TB] boot pc=%h valid=%b", pc, pc_valid);

    foreach (vecs[i]) begin
      stall = vecs[i].stall; redirect_valid = vecs[i].rv; redirect_target = vecs[i].rt;
      trap = vecs[i].trap; trap_vec = vecs[i].tv; halt_req = vecs[i].hreq;
      resume = vecs[i].res; ras_push = vecs[i].push; ras_pop = vecs[i].pop;
      step();
      $display("[TB] vec %0d pc=%h valid=%b halted=%b top=%h empty=%b mis=%b",
               i, pc, pc_valid, halted, ras_top, ras_empty, misalign);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d_plus4", i), pc_plus4, vecs[i].e_pc + 32'd4);
      chk($sformatf("v%0d_valid", i), 32'(pc_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].e_halted));
      chk($sformatf("v%0d_top", i), ras_top, vecs[i].e_top);
      chk($sformatf("v%0d_empty", i), 32'(ras_empty), 32'(vecs[i].e_empty));
      chk($sformatf("v%0d_mis", i), 32'(misalign), 32'(vecs[i].e_mis));
    end
    idle_inputs();

    // Asynchronous reset mid-cycle at pc=0x44
    stall = 1;
    #2;
    chk("pre_arst_pc", pc, 32'h44);
    rst = 1'b1;
    #1;
    $display("[TB] async reset pc=%h valid=%b", pc, pc_valid);
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", 32'(pc_valid), 32'h0);
    stall = 0;
    step();
    rst = 1'b0;
    step();
    chk("arst_run_pc", pc, 32'h0);
    chk("arst_run_valid", 32'(pc_valid), 32'h1);

    // Wrap at the top of the address space
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0; redirect_target = '0;
    $display("[TB] wrap pc=%h plus4=%h", pc, pc_plus4);
    chk("wrap_pc_hi", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    step();
    $display("[TB] wrap next pc=%h", pc);
    chk("wrap_pc_next", pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
